im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  single-cycle request to begin a program load.
REQ-004 byte_valid  input  1  source has a byte on byte_data.
REQ-005 byte_data  input  8  stream byte.
REQ-006 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-007 im_we  output  1  one-cycle write strobe to instruction memory.
REQ-008 im_waddr  output  32  byte address of the word being written, word-aligned.
REQ-009 im_wdata  output  32  instruction word being written.
REQ-010 cpu_hold  output  1  holds the CPU (PC and pipeline) while high.
REQ-011 done  output  1  load completed successfully.
REQ-012 err  output  1  load aborted on a bad length header.

Function
REQ-013 The stream format SHALL be a 2-byte big-endian word count N, then 4*N bytes, each word big-endian (MSB first).
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERR.
REQ-015 IDLE: start -> LEN_HI; byte_ready=0; cpu_hold=1.
REQ-016 LEN_HI: byte_ready=1; on transfer, latch N[15:8] -> LEN_LO.
REQ-017 LEN_LO: byte_ready=1; on transfer, latch N[7:0].
REQ-018 On leaving LEN_LO, N==0 or N>4096 SHALL go to ERR; otherwise go to DATA with word index and byte index cleared.
REQ-019 DATA: byte_ready=1; each transfer SHALL shift the byte into the low end of the word register (word = {word[23:0], byte}) and increment the byte index.
REQ-020 The 4th byte of a word SHALL go to WRITE.
REQ-021 WRITE: byte_ready=0; im_we=1 for exactly one cycle; im_wdata = assembled word; im_waddr = 32'h0000_3000 + 4*word_index.
REQ-022 From WRITE: word_index==N-1 -> DONE; otherwise increment word_index, clear the byte index -> DATA.
REQ-023 The word index SHALL be 13 bits wide, and im_waddr SHALL never exceed 32'h0000_6FFC.
REQ-024 DONE: done=1; cpu_hold=0; byte_ready=0.
REQ-025 ERR: err=1; cpu_hold=1; byte_ready=0; no further writes.
REQ-026 start in DONE or ERR SHALL clear done and err and go to LEN_HI (reload).
REQ-027 start in LEN_HI, LEN_LO, DATA or WRITE SHALL be ignored.
REQ-028 byte_valid in a state with byte_ready=0 SHALL be ignored, and the byte SHALL NOT be consumed.
REQ-029 A source stall (byte_valid=0) in any byte-accepting state SHALL hold the state and counters without limit.
REQ-030 im_we SHALL be 0 in every state except WRITE; im_waddr and im_wdata SHALL be stable during the im_we cycle.
REQ-031 cpu_hold SHALL be 1 in every state except DONE.

Reset
REQ-032 Reset SHALL force IDLE and clear N, word_index, byte index and the word register.
REQ-033 Reset SHALL set byte_ready=0, im_we=0, im_waddr=0, im_wdata=0, done=0, err=0 and cpu_hold=1.
REQ-034 Reset SHALL take priority over start and byte transfers in the same cycle.
REQ-035 Reset asserted mid-load SHALL abort the load with no write strobe on the following cycle.

Verification
REQ-036 Load 2 words, continuous valid:
  stream 00 02 24 08 00 05 00 00 00 0C
  -> im_we pulses with (0x3000, 0x24080005), then (0x3004, 0x0000000C)
  -> done=1, cpu_hold=0 on the cycle after the second write.
REQ-037 Header 00 00 -> err=1, cpu_hold=1, no im_we.
REQ-038 Header 10 01 (N=4097) -> err=1, no im_we.
REQ-039 N=1 with byte_valid deasserted for 5 cycles between bytes 2 and 3 -> single write of the correct word at 0x3000, no extra strobe.
REQ-040 Reset asserted after 6 of 8 data bytes -> IDLE, im_we=0, cpu_hold=1; a new start plus a full stream then loads from 0x3000.
REQ-041 After DONE, start plus header 00 01 and word 00 00 00 00 -> done drops, write (0x3000, 0x00000000), done=1 again.
REQ-042 N=4096 -> last write at 0x6FFC, then done.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream / instruction-memory bus of the program loader.
// The master side feeds the stream and observes the loader. The slave side is the loader itself.
interface im_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/im_loader.sv
// Program loader: parses a big-endian word-count header followed by
// big-endian instruction words from a byte stream. Each word is written into
// instruction memory starting at 0x3000. The CPU is held until the load completes.
module im_loader (
  input  logic        clk,
  input  logic        reset,
  im_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
  } state_t;

  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [15:0] MAX_WORDS = 16'd4096;

  state_t      state, state_nxt;
  logic [15:0] n_words;
  logic [12:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_reg;

  logic        xfer;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  // The full count is formed from the latched high byte and the byte being accepted.
  assign len_full  = {n_words[15:8], bus.byte_data};
  assign len_bad   = (len_full == 16'd0) || (len_full > MAX_WORDS);
  assign last_word = ({3'b000, word_idx} == (n_words - 16'd1));

  // State register. Reset takes priority over every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned and avoids inferred latches.
    state_nxt = state;
    unique case (state)
      IDLE:        if (bus.start) state_nxt = LEN_HI;
      LEN_HI:      if (xfer) state_nxt = LEN_LO;
      LEN_LO:      if (xfer) state_nxt = len_bad ? ERR : DATA;
      DATA:        if (xfer && (byte_idx == 2'd3)) state_nxt = WRITE;
      WRITE:       state_nxt = last_word ? DONE : DATA;
      DONE, ERR:   if (bus.start) state_nxt = LEN_HI;
      default:     state_nxt = IDLE;
    endcase
  end

  // Header, counters and word assembly. A word is shifted in MSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_words  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_reg <= '0;
    end else begin
      unique case (state)
        LEN_HI: if (xfer) n_words[15:8] <= bus.byte_data;
        LEN_LO: if (xfer) begin
          n_words[7:0] <= bus.byte_data;
          word_idx     <= '0;
          byte_idx     <= '0;
        end
        DATA: if (xfer) begin
          word_reg <= {word_reg[23:0], bus.byte_data};
          byte_idx <= byte_idx + 2'd1;
        end
        WRITE: if (!last_word) begin
          word_idx <= word_idx + 13'd1;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state alone. The write address and data are driven only during WRITE
  // and are zero otherwise.
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.im_we      = 1'b0;
    bus.im_waddr   = '0;
    bus.im_wdata   = '0;
    bus.cpu_hold   = 1'b1;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    unique case (state)
      LEN_HI, LEN_LO, DATA: bus.byte_ready = 1'b1;
      WRITE: begin
        bus.im_we    = 1'b1;
        bus.im_waddr = IM_BASE + {17'd0, word_idx, 2'b00};
        bus.im_wdata = word_reg;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.cpu_hold = 1'b0;
      end
      ERR:     bus.err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader.
// A stream-parsing model predicts the writes and the final status, and a negedge monitor compares them
// against the DUT.
module tb_im_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  im_loader_if bus ();

  im_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;

  logic [7:0] stim_q[$];
  wr_t        exp_q[$];
  wr_t        log_q[$];
  wr_t        exp_e;
  bit         final_is_done    = 1'b0;
  bit         expect_done_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each write strobe must match the next write the model expects.
  // Done must follow the last write by one cycle.
  always @(negedge clk) begin
    check("hold_vs_done", {31'd0, bus.cpu_hold}, {31'd0, ~bus.done});
    if (bus.im_we) check("ready_during_we", {31'd0, bus.byte_ready}, 32'd0);
    if (expect_done_next) begin
      check("done_after_last", {31'd0, bus.done}, 32'd1);
      check("hold_after_last", {31'd0, bus.cpu_hold}, 32'd0);
      expect_done_next = 1'b0;
    end
    if (bus.im_we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", {31'd0, bus.im_we}, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("waddr", bus.im_waddr, exp_e.addr);
        check("wdata", bus.im_wdata, exp_e.data);
        log_q.push_back({bus.im_waddr, bus.im_wdata});
        if (exp_q.size() == 0 && final_is_done) expect_done_next = 1'b1;
      end
    end
  end

  // Model: parse stim_q as header plus big-endian words and queue the expected writes.
  // Drive the stream with stalls and ignored start pulses.
  // If abort_after >= 0, hit reset after that many bytes.
  task automatic run_load(input int stall_pct, input int force_idx, input int force_len,
                          input int abort_after, input bit start_noise);
    int n, idx, cyc, budget, stall_left;
    bit good, forced, v;
    n    = {16'd0, stim_q[0], stim_q[1]};
    good = (n >= 1) && (n <= 4096);
    if (good) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({32'h0000_3000 + 32'(4 * i),
                         stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i], stim_q[5+4*i]});
    end
    final_is_done = good;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.byte_valid = 1'($urandom_range(0, 1));
    bus.byte_data  = 8'hA5;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_clears_done", {31'd0, bus.done}, 32'd0);
    check("start_clears_err", {31'd0, bus.err}, 32'd0);
    check("len_hi_ready", {31'd0, bus.byte_ready}, 32'd1);

    idx = 0; cyc = 0; stall_left = 0; forced = 1'b0;
    budget = stim_q.size() * 4 + force_len + 200;
    while (idx < stim_q.size() && idx != abort_after && cyc < budget) begin
      if (idx == force_idx && !forced) begin
        forced     = 1'b1;
        stall_left = force_len;
      end
      if (stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else begin
        v = ($urandom_range(0, 99) >= stall_pct);
      end
      bus.start      = start_noise && ($urandom_range(0, 15) == 0);
      bus.byte_valid = v;
      bus.byte_data  = v ? stim_q[idx] : 8'($urandom);
      if (bus.byte_ready && v) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    if (cyc >= budget) check("stream_timeout", 32'(idx), 32'(stim_q.size()));

    if (abort_after >= 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_we", {31'd0, bus.im_we}, 32'd0);
      check("abort_hold", {31'd0, bus.cpu_hold}, 32'd1);
      check("abort_ready", {31'd0, bus.byte_ready}, 32'd0);
      exp_q.delete();
      expect_done_next = 1'b0;
      return;
    end

    cyc = 0;
    while (!(bus.done || bus.err) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("final_done", {31'd0, bus.done}, {31'd0, good});
    check("final_err", {31'd0, bus.err}, {31'd0, !good});
    check("final_hold", {31'd0, bus.cpu_hold}, {31'd0, !good});
    check("writes_left", 32'(exp_q.size()), 32'd0);

    // Bytes offered in DONE or ERR are not accepted and leave the status unchanged.
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      check("no_ready_after", {31'd0, bus.byte_ready}, 32'd0);
    end
    bus.byte_valid = 1'b0;
    @(negedge clk);
    check("status_held", {30'd0, bus.done, bus.err}, good ? 32'd2 : 32'd1);
  endtask

  task automatic make_stream(input int n, input bit with_data);
    stim_q.delete();
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
    if (with_data) for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
  endtask

  initial begin
    int n, r;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_we", {31'd0, bus.im_we}, 32'd0);
    check("rst_waddr", bus.im_waddr, 32'd0);
    check("rst_wdata", bus.im_wdata, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_hold", {31'd0, bus.cpu_hold}, 32'd1);
    reset = 1'b0;

    // Two words with continuous valid.
    stim_q = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    log_q.delete();
    run_load(0, -1, 0, -1, 1'b0);
    check("two_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("two_a0", log_q[0].addr, 32'h0000_3000);
      check("two_d0", log_q[0].data, 32'h2408_0005);
      check("two_a1", log_q[1].addr, 32'h0000_3004);
      check("two_d1", log_q[1].data, 32'h0000_000C);
    end

    // Reload from DONE with a single zero word.
    stim_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    log_q.delete();
    run_load(0, -1, 0, -1, 1'b0);
    check("reload_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      check("reload_a", log_q[0].addr, 32'h0000_3000);
      check("reload_d", log_q[0].data, 32'h0000_0000);
    end

    // Bad headers: zero words and 4097 words.
    stim_q = '{8'h00, 8'h00};
    log_q.delete();
    run_load(0, -1, 0, -1, 1'b0);
    check("n0_writes", 32'(log_q.size()), 32'd0);
    stim_q = '{8'h10, 8'h01};
    run_load(0, -1, 0, -1, 1'b0);
    check("n4097_writes", 32'(log_q.size()), 32'd0);

    // One word with a 5-cycle source stall between data bytes 2 and 3.
    make_stream(1, 1'b1);
    log_q.delete();
    run_load(0, 4, 5, -1, 1'b0);
    check("stall_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      check("stall_a", log_q[0].addr, 32'h0000_3000);
      check("stall_d", log_q[0].data, {stim_q[2], stim_q[3], stim_q[4], stim_q[5]});
    end

    // Reset after 6 of 8 data bytes, then a fresh load from IDLE.
    make_stream(2, 1'b1);
    log_q.delete();
    run_load(0, -1, 0, 8, 1'b0);
    check("abort_writes", 32'(log_q.size()), 32'd1);
    make_stream(2, 1'b1);
    log_q.delete();
    run_load(10, -1, 0, -1, 1'b0);
    check("after_abort_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) check("after_abort_a0", log_q[0].addr, 32'h0000_3000);

    // Random loads: stalls, ignored start pulses and occasional bad headers.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = 0;
      else if (r == 1) n = $urandom_range(4097, 65535);
      else             n = $urandom_range(1, 8);
      make_stream(n, (n >= 1 && n <= 4096));
      run_load($urandom_range(0, 30), -1, 0, -1, 1'b1);
    end

    // Largest legal load: the last write lands at 0x6FFC.
    make_stream(4096, 1'b1);
    log_q.delete();
    run_load(0, -1, 0, -1, 1'b0);
    check("max_count", 32'(log_q.size()), 32'd4096);
    if (log_q.size() == 4096) check("max_last_addr", log_q[4095].addr, 32'h0000_6FFC);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
